// File: rtl/julia_pkg.sv
// Shared definitions for the Julia pixel writer.
// Contents: default raster size, pixel count, frame_ms ceiling, writer FSM state type and the
// iteration-count to RGB332 colour map.
// Optional build macro: JULIA_WRITER_GRAYSCALE_EN selects a grey ramp for out-of-set pixels.
package julia_pkg;

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;
  localparam int unsigned NUM_PIXELS    = H_RES_DEFAULT * V_RES_DEFAULT;
  localparam int unsigned MS_MAX        = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // In-set pixels (count reached the limit) are black; num_iter = 0 blacks out every pixel.
  function automatic logic [7:0] colour_map(input logic [9:0] iter, input logic [9:0] limit);
    logic [7:0] c;
    if (iter >= limit) begin
      c = 8'h00;
    end else begin
`ifdef JULIA_WRITER_GRAYSCALE_EN
      c = {iter[7:5], iter[7:5], iter[7:6]};
`else
      c = {iter[2:0], iter[5:3], iter[7:6]};
`endif
    end
    return c;
  endfunction

endpackage

// File: rtl/julia_pixel_writer_if.sv
// Pixel handshake plus VGA pixel-buffer slave bus.
// Signals: pix_valid/pix_ready/pix_iter (solver -> writer), vga_address/vga_clken/
// vga_chipselect/vga_write/vga_writedata (writer -> buffer).
// Modports: master = the writer (drives the buffer bus, accepts pixels); slave = the far side.
interface julia_pixel_writer_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              pix_valid;
  logic              pix_ready;
  logic [9:0]        pix_iter;
  logic [ADDR_W-1:0] vga_address;
  logic              vga_clken;
  logic              vga_chipselect;
  logic              vga_write;
  logic [7:0]        vga_writedata;

  modport master (
    input  pix_valid, pix_iter,
    output pix_ready, vga_address, vga_clken, vga_chipselect, vga_write, vga_writedata
  );

  modport slave (
    output pix_valid, pix_iter,
    input  pix_ready, vga_address, vga_clken, vga_chipselect, vga_write, vga_writedata
  );
endinterface

// File: rtl/ms_timer.sv
// Millisecond frame timer: a prescaler counting clk cycles and a 10-bit ms counter that
// saturates at 1023.
// Ports: clk, reset_n (async active-low), i_clear (zero both counters, wins over enable),
// i_enable (count this cycle), o_ms (elapsed milliseconds).
module ms_timer
  import julia_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic [9:0] o_ms
);

  localparam int unsigned PrescW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CYCLES_PER_MS - 1);
  localparam logic [9:0] MsMax = 10'(MS_MAX);

  logic [PrescW-1:0] r_presc;
  logic [9:0]        r_ms;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else if (i_enable) begin
      if (r_presc == PrescLast) begin
        r_presc <= '0;
        if (r_ms != MsMax) r_ms <= r_ms + 10'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign o_ms = r_ms;

endmodule

// File: rtl/julia_pixel_writer.sv
// Julia pixel writer: accepts raster-order iteration counts, colour-maps them and writes one
// RGB332 pixel per accepted count into the VGA pixel buffer, timing each frame in ms.
// Ports: clk, reset_n (async active-low), start (begin/restart frame), num_iter (iteration
// limit), bus (pixel handshake + buffer bus, master side), busy, frame_done (pulse with the
// final write), frame_ms (elapsed ms of current/last frame).
// Optional build macro: JULIA_WRITER_GRAYSCALE_EN (grey-ramp colour map, see julia_pkg).
// ADDR_W must satisfy 2**ADDR_W >= H_RES*V_RES.
module julia_pixel_writer
  import julia_pkg::*;
#(
  parameter int unsigned H_RES         = H_RES_DEFAULT,
  parameter int unsigned V_RES         = V_RES_DEFAULT,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned CYCLES_PER_MS = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [9:0]           num_iter,
  julia_pixel_writer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [9:0]           frame_ms
);

  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(H_RES * V_RES - 1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_vga_write;
  logic [ADDR_W-1:0] r_vga_address;
  logic [7:0]        r_vga_writedata;
  logic              r_frame_done;
  logic              w_xfer;
  logic              w_last;

  // start takes priority over a pending pixel, so no transfer happens on a restart cycle.
  assign bus.pix_ready = (r_state == RUN) & ~start;
  assign w_xfer        = bus.pix_valid & bus.pix_ready;
  assign w_last        = (r_pix_cnt == LastPix);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (start) w_state_d = RUN;
      RUN: begin
        if (start)                w_state_d = RUN;
        else if (w_xfer && w_last) w_state_d = DONE;
      end
      DONE:    if (start) w_state_d = RUN;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_cnt       <= '0;
      r_vga_write     <= 1'b0;
      r_vga_address   <= '0;
      r_vga_writedata <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      r_vga_write  <= w_xfer;
      r_frame_done <= w_xfer & w_last;
      if (start) begin
        r_pix_cnt <= '0;
      end else if (w_xfer) begin
        r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
      end
      // Address and data hold between writes.
      if (w_xfer) begin
        r_vga_address   <= r_pix_cnt;
        r_vga_writedata <= colour_map(bus.pix_iter, num_iter);
      end
    end
  end

  assign bus.vga_clken      = 1'b1;
  assign bus.vga_write      = r_vga_write;
  assign bus.vga_chipselect = r_vga_write;
  assign bus.vga_address    = r_vga_address;
  assign bus.vga_writedata  = r_vga_writedata;
  assign busy               = (r_state == RUN);
  assign frame_done         = r_frame_done;

  ms_timer #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_ms_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (start),
    .i_enable(busy & ~start),
    .o_ms    (frame_ms)
  );

endmodule
